// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end: fetch FSM states,
// reset PC default and primary opcodes used by the decoder.
package mips_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    function automatic logic [5:0] opcode(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the
// instruction-register handshake and redirect inputs from decode/ALU.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] signimm;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, branch, zero, jump, signimm
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready, branch, zero, jump, signimm
    );
endinterface

// File: rtl/pc_next.sv
// Next-PC mux: sequential, taken branch or jump target. Jump wins over
// branch; all arithmetic wraps modulo 2^32.
module pc_next (
    input  logic [31:0] pc,
    input  logic [25:0] target,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic [31:0] pcplus4,
    output logic [31:0] pcnext
);
    assign pcplus4 = pc + 32'd4;

    // NOTE: default first so every path assigns pcnext and no latch is inferred.
    always_comb begin
        pcnext = pcplus4;
        if (jump)
            pcnext = {pcplus4[31:28], target, 2'b00};
        else if (branch && zero)
            pcnext = pcplus4 + (signimm << 2);
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR and fetch/issue FSM.
// Optional imem_ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus,
    output logic [31:0]  pc,
    output logic [31:0]  pcplus4,
    output logic [31:0]  retired,
    output logic         fetch_fault
);
    fetch_state_t state, state_next;
    logic         req_q;
    logic [31:0]  instr_q;
    logic [31:0]  pcnext;
    logic         ir_load;
    logic         accept;
    logic         timeout_hit;

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == S_ISSUE);

    pc_next u_pc_next (
        .pc      (pc),
        .target  (instr_q[25:0]),
        .branch  (bus.branch),
        .zero    (bus.zero),
        .jump    (bus.jump),
        .signimm (bus.signimm),
        .pcplus4 (pcplus4),
        .pcnext  (pcnext)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (req_q && bus.imem_ack) state_next = S_ISSUE;
                else if (timeout_hit)      state_next = S_HALT;
            end
            S_ISSUE: if (bus.instr_ready) state_next = S_FETCH;
            default: state_next = state;
        endcase
    end

    // ack only counts while a request is actually on the bus
    always_comb begin
        ir_load = 1'b0;
        accept  = 1'b0;
        case (state)
            S_FETCH: ir_load = req_q & bus.imem_ack;
            S_ISSUE: accept  = bus.instr_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= 1'b0;
            instr_q <= '0;
            pc      <= RESET_PC;
            retired <= '0;
        end else begin
            req_q <= (state_next == S_FETCH);
            if (ir_load) instr_q <= bus.imem_rdata;
            if (accept) begin
                pc      <= pcnext;
                retired <= retired + 32'd1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        fault_q;
    logic        waiting;

    assign waiting     = (state == S_FETCH) && req_q && !bus.imem_ack;
    assign timeout_hit = waiting && (wait_cnt == 16'(TIMEOUT - 1));
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (accept)       wait_cnt <= '0;
            else if (waiting) wait_cnt <= wait_cnt + 16'd1;
            if (timeout_hit)  fault_q  <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// stall/reset sequences and randomized fetch/issue against a PC model.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc, pcplus4, retired;
    logic        fetch_fault;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RPC), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .retired     (retired),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_instr;

    typedef struct {
        logic [31:0] rdata;
        int          ack_dly;
        int          rdy_dly;
        logic        br;
        logic        z;
        logic        j;
        logic [31:0] imm;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference next PC from the architectural rules, plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic br, input logic z, input logic j,
                                             input logic [31:0] imm);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (j)       return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        if (br && z) return seq + imm * 32'd4;
        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req === 1'b1) break;
            tick();
        end
        check("imem_req_rise", {31'd0, bus.imem_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] rdata, input int ack_dly);
        wait_req();
        check("imem_addr", bus.imem_addr, m_pc);
        repeat (ack_dly) begin
            bus.imem_ack = 1'b0;
            tick();
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        m_instr = rdata;
        check("instr", bus.instr, m_instr);
        check("instr_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("imem_req_drop", {31'd0, bus.imem_req}, 32'd0);
    endtask

    task automatic issue(input int rdy_dly, input logic br, input logic z, input logic j,
                         input logic [31:0] imm, input logic [31:0] exp_pc);
        repeat (rdy_dly) begin
            bus.instr_ready = 1'b0;
            bus.branch      = 1'($urandom);
            bus.zero        = 1'($urandom);
            bus.jump        = 1'($urandom);
            bus.signimm     = $urandom;
            bus.imem_ack    = 1'($urandom);
            bus.imem_rdata  = $urandom;
            tick();
        end
        bus.imem_ack = 1'b0;
        check("instr_hold", bus.instr, m_instr);
        check("pcplus4", pcplus4, m_pc + 32'd4);
        bus.instr_ready = 1'b1;
        bus.branch      = br;
        bus.zero        = z;
        bus.jump        = j;
        bus.signimm     = imm;
        tick();
        bus.instr_ready = 1'b0;
        bus.branch      = 1'($urandom);
        bus.zero        = 1'($urandom);
        bus.jump        = 1'($urandom);
        bus.signimm     = $urandom;
        m_ret = m_ret + 32'd1;
        m_pc  = exp_pc;
        check("pc", pc, m_pc);
        check("retired", retired, m_ret);
        check("valid_clear", {31'd0, bus.instr_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        bus.jump        = 1'b0;
        bus.signimm     = '0;
        m_pc  = RPC;
        m_ret = '0;
        m_instr = '0;

        //            rdata         ack rdy br    z     j     imm           exp_pc
        vecs[0] = '{32'h2008_0005, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004};
        vecs[1] = '{32'h0800_0010, 0, 1, 1'b1, 1'b1, 1'b1, 32'h5,         32'h0000_0040};
        vecs[2] = '{32'h0800_0002, 1, 0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0008};
        vecs[3] = '{32'h1000_FFFE, 0, 2, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0004};
        vecs[4] = '{32'h0800_0002, 3, 0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0008};
        vecs[5] = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_000C};
        vecs[6] = '{32'h1000_0003, 1, 1, 1'b1, 1'b1, 1'b0, 32'h3,         32'h0000_001C};
        vecs[7] = '{32'h1000_FFF7, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF7, 32'hFFFF_FFFC};
        vecs[8] = '{32'h2008_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, RPC);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("req_low_after_release", {31'd0, bus.imem_req}, 32'd0);

        // directed vectors, each a full fetch + issue
        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].rdata, vecs[i].ack_dly);
            issue(vecs[i].rdy_dly, vecs[i].br, vecs[i].z, vecs[i].j, vecs[i].imm, vecs[i].exp_pc);
        end

        // issue stall: instr_ready low 5 cycles with spurious acks
        fetch(32'hAAAA_5555, 1);
        for (int i = 0; i < 5; i++) begin
            bus.instr_ready = 1'b0;
            bus.imem_ack    = 1'b1;
            bus.imem_rdata  = 32'h1234_0000 + 32'(i);
            tick();
            check("stall_instr", bus.instr, 32'hAAAA_5555);
            check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            check("stall_pc", pc, m_pc);
            check("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.imem_ack = 1'b0;
        issue(0, 1'b0, 1'b0, 1'b0, 32'h0, ref_next(m_pc, m_instr, 1'b0, 1'b0, 1'b0, 32'h0));

        // reset in the middle of a fetch, then a late ack before req rises
        wait_req();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_pc", pc, RPC);
        check("midrst_instr", bus.instr, 32'h0);
        check("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        check("midrst_retired", retired, 32'd0);
        m_pc  = RPC;
        m_ret = '0;
        @(negedge clk);
        reset_n        = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        check("late_ack_instr", bus.instr, 32'h0);
        check("late_ack_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("late_ack_req", {31'd0, bus.imem_req}, 32'd1);

        // randomized fetch/issue against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] rd, imm;
            logic        br, z, j;
            rd  = $urandom;
            br  = 1'($urandom);
            z   = 1'($urandom);
            j   = ($urandom_range(0, 3) == 0);
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
            fetch(rd, int'($urandom_range(0, 3)));
            issue(int'($urandom_range(0, 3)), br, z, j, imm, ref_next(m_pc, rd, br, z, j, imm));
        end

`ifdef FETCH_TIMEOUT_EN
        // watchdog: no ack for 16 request cycles halts the fetch stage
        reset_n = 1'b0;
        #1;
        m_pc  = RPC;
        m_ret = '0;
        @(negedge clk);
        reset_n = 1'b1;
        wait_req();
        repeat (15) tick();
        check("fault_before_limit", {31'd0, fetch_fault}, 32'd0);
        tick();
        check("fault_at_limit", {31'd0, fetch_fault}, 32'd1);
        check("halt_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ack = 1'b1;
        repeat (4) tick();
        bus.imem_ack = 1'b0;
        check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("halt_fault_sticky", {31'd0, fetch_fault}, 32'd1);
        check("halt_pc", pc, RPC);
`else
        check("fault_tied_low", {31'd0, fetch_fault}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
